mdu: RTL and testbench

Multi-cycle multiply/divide unit with HI/LO registers, sitting in the EX stage beside the ALU, directly upstream of the memory stage. Executes MULT/MULTU/DIV/DIVU with fixed latencies and performs MTHI/MTLO writes. Exposes HI/LO for MFHI/MFLO results forwarded into the EX/MEM pipeline register. Provides `busy` to the hazard unit, which stalls any dependent HI/LO instruction in D.

---
 rtl/mdu.sv | 116 +++++++++++
 tb/tb_mdu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles; MTHI/MTLO in one edge; start is ignored while busy.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC + 1) > 4) ? $clog2(MAXC + 1) : 4;
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_op;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic          r_busy;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    // Signed multiply: sign-extend to 64 bits, the low 64 bits of the product are exact.
    logic [63:0] w_ma;
    logic [63:0] w_mb;
    logic [63:0] w_prod;
    assign w_ma   = (r_op == OP_MULT) ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_mb   = (r_op == OP_MULT) ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    assign w_prod = w_ma * w_mb;

    // Signed divide works on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    logic        w_sdiv;
    logic [31:0] w_amag;
    logic [31:0] w_bmag;
    logic [31:0] w_qmag;
    logic [31:0] w_rmag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    assign w_sdiv = (r_op == OP_DIV);
    assign w_amag = (w_sdiv && r_a[31]) ? -r_a : r_a;
    assign w_bmag = (w_sdiv && r_b[31]) ? -r_b : r_b;
    assign w_qmag = w_amag / w_bmag;
    assign w_rmag = w_amag % w_bmag;
    assign w_quo  = (w_sdiv && (r_a[31] ^ r_b[31])) ? -w_qmag : w_qmag;
    assign w_rem  = (w_sdiv && r_a[31]) ? -w_rmag : w_rmag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (mdOp)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_op    <= mdOp;
                                r_a     <= A;
                                r_b     <= B;
                                r_cnt   <= (mdOp == OP_MULT || mdOp == OP_MULTU) ? MULT_LD : DIV_LD;
                                r_busy  <= 1'b1;
                                r_state <= S_BUSY;
                            end
                            OP_MTHI: r_hi <= A;
                            OP_MTLO: r_lo <= A;
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        if (r_op == OP_MULT || r_op == OP_MULTU) begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end else if (r_b != 32'd0) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;
endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: vector table plus hand-written busy/reset/back-to-back sequences.
module tb_mdu;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .mdOp(mdOp),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        keep;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    vec_t        vecs[10];
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e);
        start = 1'b1;
        mdOp  = op;
        A     = a;
        B     = b;
        sb.push_back(e);
        check("busy_in_start_cycle", {31'd0, busy}, 32'd0);
        tick();
        start = 1'b0;
        mdOp  = 3'd0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic finish_op(input string nm, input int pre);
        int   n;
        exp_t e;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_sb: got empty scoreboard expected entry", nm);
        end else begin
            e = sb.pop_front();
            check({nm, "_cyc"}, 32'(n + pre), 32'(e.cyc));
            check({nm, "_hi"}, HI, e.hi);
            check({nm, "_lo"}, LO, e.lo);
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    initial begin
        exp_t e;

        vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 5};
        vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, 5};
        vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 10};
        vecs[3] = '{3'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 10};
        vecs[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 10};
        vecs[5] = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 10};
        vecs[6] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 5};
        vecs[7] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 5};
        vecs[8] = '{3'd4, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 10};
        vecs[9] = '{3'd3, 32'h00001234, 32'h00000000, 32'h0,        32'h0,        1'b1, 10};

        reset = 1'b0;
        start = 1'b0;
        mdOp  = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        #2 reset = 1'b1;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            e.hi  = vecs[i].keep ? m_hi : vecs[i].hi;
            e.lo  = vecs[i].keep ? m_lo : vecs[i].lo;
            e.cyc = vecs[i].cyc;
            launch(vecs[i].op, vecs[i].a, vecs[i].b, e);
            finish_op($sformatf("vec%0d", i), 0);
        end

        // Opcodes 0 and 7 must leave everything alone.
        start = 1'b1; mdOp = 3'd0; A = 32'h55555555; tick();
        mdOp = 3'd7; tick();
        start = 1'b0;
        check("nop_busy", {31'd0, busy}, 32'd0);
        check("nop_hi", HI, m_hi);
        check("nop_lo", LO, m_lo);

        // MTHI then MTLO on consecutive cycles, then divide by zero keeps them.
        start = 1'b1; mdOp = 3'd5; A = 32'h12345678; tick();
        check("mthi_hi", HI, 32'h12345678);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        mdOp = 3'd6; A = 32'h9ABCDEF0; tick();
        start = 1'b0;
        check("mtlo_lo", LO, 32'h9ABCDEF0);
        check("mtlo_hi", HI, 32'h12345678);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        e = '{32'h12345678, 32'h9ABCDEF0, 10};
        launch(3'd3, 32'd5, 32'd0, e);
        finish_op("divzero", 0);

        // Starts while busy are ignored, operand changes too.
        e = '{32'hFFFFFFFF, 32'hFFFFFFFD, 5};
        launch(3'd1, 32'hFFFFFFFF, 32'd3, e);
        tick();
        start = 1'b1; mdOp = 3'd2; A = 32'd7; B = 32'd9; tick();
        mdOp = 3'd6; A = 32'hDEADBEEF; tick();
        start = 1'b0; mdOp = 3'd0; A = 32'd5; B = 32'd11;
        finish_op("ignored_starts", 3);

        // Reset on busy cycle 4 of a DIV aborts it asynchronously.
        e = '{32'd1, 32'd33, 10};
        launch(3'd3, 32'd100, 32'd3, e);
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        sb.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        tick();
        reset = 1'b0;
        tick();
        e = '{32'd0, 32'd12, 5};
        launch(3'd2, 32'd3, 32'd4, e);
        finish_op("post_reset", 0);

        // Back-to-back: DIVU starts in the cycle busy falls.
        e = '{32'hFFFFFFFE, 32'h00000001, 5};
        launch(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, e);
        finish_op("b2b_mul", 0);
        e = '{32'd2, 32'd14, 10};
        launch(3'd4, 32'd100, 32'd7, e);
        finish_op("b2b_div", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
